// File: rtl/fsk_demod_pkg.sv
// Shared types for the zero-crossing FSK word demodulator:
// decoder states and half-period interval classes.
package fsk_demod_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      READY  = 2'b01,
      SHORT1 = 2'b10
   } state_e;

   typedef enum logic {
      SHORT = 1'b0,
      LONG  = 1'b1
   } cls_e;

endpackage

// File: rtl/zc_period_meter.sv
// Zero-crossing interval meter: tracks the reference sign, rejects glitch edges,
// counts samples between accepted edges and classifies each interval.
module zc_period_meter
   import fsk_demod_pkg::*;
#(
   parameter int SAMPLE_W  = 8,
   parameter int CNT_W     = 8,
   parameter int MIN_HALF  = 3,
   parameter int SHORT_MAX = 24,
   parameter int LONG_MAX  = 80
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                edge_stb,
   output cls_e                edge_cls,
   output logic                tmo_stb
);

   localparam logic [CNT_W:0]   MIN_L   = (CNT_W+1)'(MIN_HALF);
   localparam logic [CNT_W:0]   SHORT_L = (CNT_W+1)'(SHORT_MAX);
   localparam logic [CNT_W:0]   LONG_L  = (CNT_W+1)'(LONG_MAX);
   localparam logic [CNT_W:0]   LEN_ONE = (CNT_W+1)'(1);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

   logic             ref_sign_r;
   logic [CNT_W-1:0] c_r;
   logic [CNT_W:0]   len_s;
   logic             sign_s;
   logic             cand_s;
   logic             accept_s;

   // Interval length including this sample, edge qualification and classification.
   // An accepted edge beyond LONG_MAX also raises tmo_stb; the decoder gives timeout priority.
   always_comb begin
      sign_s   = sample_in[SAMPLE_W-1];
      len_s    = {1'b0, c_r} + LEN_ONE;
      cand_s   = sample_valid && (sign_s != ref_sign_r);
      accept_s = cand_s && (len_s >= MIN_L);
      edge_stb = accept_s;
      tmo_stb  = sample_valid && (len_s > LONG_L);
      if (len_s <= SHORT_L) begin
         edge_cls = SHORT;
      end else begin
         edge_cls = LONG;
      end
   end

   // Reference sign and saturating sample counter since the last accepted edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_sign_r <= 1'b0;
         c_r        <= '0;
      end else if (accept_s) begin
         ref_sign_r <= sign_s;
         c_r        <= '0;
      end else if (sample_valid && (c_r != '1)) begin
         c_r <= c_r + C_ONE;
      end
   end

endmodule

// File: rtl/fsk_word_demod.sv
// FSK demodulator top: symbol state machine over measured half-periods,
// MSB-first word assembly and a valid/ready word output with overrun detection.
module fsk_word_demod
   import fsk_demod_pkg::*;
#(
   parameter int SAMPLE_W  = 8,
   parameter int CNT_W     = 8,
   parameter int MIN_HALF  = 3,
   parameter int SHORT_MAX = 24,
   parameter int LONG_MAX  = 80,
   parameter int WORD_W    = 16
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                bit_out,
   output logic                bit_valid,
   output logic [WORD_W-1:0]   word_out,
   output logic                word_valid,
   input  logic                word_ready,
   output logic                sym_err,
   output logic                timeout,
   output logic                overrun
);

   localparam int              BC_W     = $clog2(WORD_W + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
   localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1);

   logic              edge_stb_s;
   cls_e              edge_cls_s;
   logic              tmo_stb_s;
   state_e            state_r;
   state_e            state_nxt_s;
   logic              emit_s;
   logic              emit_bit_s;
   logic              sym_s;
   logic              tmo_s;
   logic              clear_s;
   logic              done_s;
   logic              drop_s;
   logic [BC_W-1:0]   bit_cnt_r;
   logic [WORD_W-1:0] shift_r;
   logic [WORD_W-1:0] shift_nxt_s;

   zc_period_meter #(
      .SAMPLE_W  (SAMPLE_W),
      .CNT_W     (CNT_W),
      .MIN_HALF  (MIN_HALF),
      .SHORT_MAX (SHORT_MAX),
      .LONG_MAX  (LONG_MAX)
   ) u_meter (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .edge_stb     (edge_stb_s),
      .edge_cls     (edge_cls_s),
      .tmo_stb      (tmo_stb_s)
   );

   // Symbol decoding: next state, emitted bit and error strobes.
   always_comb begin
      state_nxt_s = state_r;
      emit_s      = 1'b0;
      emit_bit_s  = 1'b0;
      sym_s       = 1'b0;
      tmo_s       = 1'b0;
      clear_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (edge_stb_s) begin
               state_nxt_s = READY;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         READY: begin
            if (tmo_stb_s) begin
               tmo_s       = 1'b1;
               clear_s     = 1'b1;
               state_nxt_s = IDLE;
            end else if (edge_stb_s) begin
               if (edge_cls_s == LONG) begin
                  emit_s      = 1'b1;
                  emit_bit_s  = 1'b1;
                  state_nxt_s = READY;
               end else begin
                  state_nxt_s = SHORT1;
               end
            end else begin
               state_nxt_s = READY;
            end
         end
         SHORT1: begin
            if (tmo_stb_s) begin
               tmo_s       = 1'b1;
               clear_s     = 1'b1;
               state_nxt_s = IDLE;
            end else if (edge_stb_s) begin
               if (edge_cls_s == SHORT) begin
                  emit_s     = 1'b1;
                  emit_bit_s = 1'b0;
               end else begin
                  sym_s   = 1'b1;
                  clear_s = 1'b1;
               end
               state_nxt_s = READY;
            end else begin
               state_nxt_s = SHORT1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      shift_nxt_s = {shift_r[WORD_W-2:0], emit_bit_s};
      done_s      = emit_s && (bit_cnt_r == LAST_BIT);
      drop_s      = done_s && word_valid && !word_ready;
   end

   // Decoder state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Word assembly, registered strobes and the output handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_out    <= 1'b0;
         bit_valid  <= 1'b0;
         sym_err    <= 1'b0;
         timeout    <= 1'b0;
         overrun    <= 1'b0;
         bit_cnt_r  <= '0;
         shift_r    <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
      end else begin
         bit_valid <= emit_s;
         sym_err   <= sym_s;
         timeout   <= tmo_s;
         overrun   <= drop_s;
         if (emit_s) begin
            bit_out <= emit_bit_s;
         end
         if (clear_s || done_s) begin
            bit_cnt_r <= '0;
            shift_r   <= '0;
         end else if (emit_s) begin
            bit_cnt_r <= bit_cnt_r + BC_ONE;
            shift_r   <= shift_nxt_s;
         end
         // A word completing while the old one is unaccepted is dropped.
         if (done_s && !drop_s) begin
            word_out   <= shift_nxt_s;
            word_valid <= 1'b1;
         end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule
